// File: rtl/lcd_write_strobe.sv
// lcd_write_strobe: LCD E-strobe write sequencer with setup/pulse/hold timing and optional nibble mode.
// Optional feature: define LCD_STROBE_OVERRUN_EN to add the sticky oOverrun flag.
module lcd_write_strobe #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 12,
    parameter int HOLD_CYCLES  = 2,
    parameter int GAP_CYCLES   = 4,
    parameter int CNT_W        = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iNibbleMode,
    output logic       oBusy,
    output logic       oDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RS,
    output logic [7:0] oLCD_Data
`ifdef LCD_STROBE_OVERRUN_EN
    ,
    output logic       oOverrun
`endif
);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP, DONE} state_t;

    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] timer, timer_nx, span_last;
    logic             expired;
    logic [7:0]       data_q, drive;
    logic             rs_q, nib_q, second;

    // Next state and timer: the timer restarts on every state change and a state ends at count == N-1
    always_comb begin
        span_last = state == SETUP ? S_LAST : state == PULSE ? P_LAST : state == HOLD ? H_LAST : G_LAST;
        expired   = timer == span_last;
        state_nx  = state;
        case (state)
            IDLE:    state_nx = iStart ? SETUP : IDLE;
            SETUP:   state_nx = expired ? PULSE : SETUP;
            PULSE:   state_nx = expired ? HOLD : PULSE;
            HOLD:    state_nx = expired ? ((nib_q && !second) ? GAP : DONE) : HOLD;
            GAP:     state_nx = expired ? SETUP : GAP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        timer_nx = (state_nx != state || state_nx == IDLE) ? '0 : timer + 1'b1;
        drive    = nib_q ? {(second ? data_q[3:0] : data_q[7:4]), 4'h0} : data_q;
    end

    // Sequencer state, timer and the transfer captured at the accepting edge
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state  <= IDLE;
            timer  <= '0;
            data_q <= '0;
            rs_q   <= 1'b0;
            nib_q  <= 1'b0;
            second <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            if (state == IDLE && iStart) begin
                data_q <= iData;
                rs_q   <= iRS;
                nib_q  <= iNibbleMode;
                second <= 1'b0;
            end else if (state == GAP && state_nx == SETUP) begin
                second <= 1'b1;
            end
        end
    end

    // Registered outputs follow the state one cycle later; bus and RS hold their value while idle
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oLCD_Enabled <= 1'b0;
            oLCD_RS      <= 1'b0;
            oLCD_Data    <= '0;
        end else begin
            oBusy        <= state != IDLE;
            oDone        <= state == DONE;
            oLCD_Enabled <= state == PULSE;
            if (state != IDLE) begin
                oLCD_RS   <= rs_q;
                oLCD_Data <= drive;
            end
        end
    end

`ifdef LCD_STROBE_OVERRUN_EN
    // Sticky flag for a start request that arrives while a transfer is in progress
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) oOverrun <= 1'b0;
        else if (iStart && state != IDLE) oOverrun <= 1'b1;
    end
`endif
endmodule

// File: doc/lcd_write_strobe.md
LCD_WRITE_STROBE -- requirements
Module: lcd_write_strobe

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, cycles oLCD_Data/oLCD_RS are stable before oLCD_Enabled rises (min 1).
REQ-002 SHALL have parameter PULSE_CYCLES, default 12, cycles oLCD_Enabled is held high (min 1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, cycles data is held after oLCD_Enabled falls (min 1).
REQ-004 SHALL have parameter GAP_CYCLES, default 4, idle cycles between the two nibbles in nibble mode (min 1).
REQ-005 SHALL have parameter CNT_W, default 8, timer width; every *_CYCLES value must be below 2^CNT_W.
REQ-006 SHALL have port Clock, input, 1, single rising-edge clock.
REQ-007 SHALL have port Reset, input, 1; one clock, and Reset is asynchronous and active-low.
REQ-008 SHALL have port iStart, input, 1, request to write one byte.
REQ-009 SHALL have port iData, input, 8, byte to write.
REQ-010 SHALL have port iRS, input, 1, register select to drive with the byte.
REQ-011 SHALL have port iNibbleMode, input, 1; 1 = 4-bit bus, two strobes; 0 = 8-bit bus, one strobe.
REQ-012 SHALL have port oBusy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port oDone, output, 1, single-cycle completion pulse.
REQ-014 SHALL have port oLCD_Enabled, output, 1, LCD E strobe.
REQ-015 SHALL have port oLCD_RS, output, 1, LCD RS line.
REQ-016 SHALL have port oLCD_Data, output, 8, LCD data bus.

Function
REQ-017 SHALL implement states IDLE, SETUP, PULSE, HOLD, GAP and DONE, with all outputs registered.
REQ-018 In IDLE, iStart=1 at an edge SHALL latch iData, iRS and iNibbleMode, and enter SETUP on the next cycle.
REQ-019 iStart SHALL be ignored in every state other than IDLE; the latched values SHALL NOT change mid-transfer.
REQ-020 SETUP SHALL last exactly SETUP_CYCLES cycles, with oLCD_Enabled=0 and data/RS driven.
REQ-021 SETUP SHALL be followed by PULSE, which lasts exactly PULSE_CYCLES cycles with oLCD_Enabled=1.
REQ-022 PULSE SHALL be followed by HOLD, which lasts exactly HOLD_CYCLES cycles with oLCD_Enabled=0 and data/RS unchanged.
REQ-023 In 8-bit mode, oLCD_Data SHALL equal the latched byte, and HOLD SHALL go to DONE.
REQ-024 In nibble mode, the first pass SHALL drive oLCD_Data[7:4] with the high nibble and oLCD_Data[3:0] with 0.
REQ-025 In nibble mode, HOLD SHALL then go to GAP, which lasts GAP_CYCLES cycles with oLCD_Enabled=0.
REQ-026 GAP SHALL go to SETUP with the low nibble on oLCD_Data[7:4]; the second HOLD SHALL go to DONE.
REQ-027 DONE SHALL last 1 cycle with oDone=1 and then return to IDLE; iStart in DONE SHALL be ignored.
REQ-028 Latency from the accepting edge to oDone SHALL be 1+S+P+H cycles in 8-bit mode.
REQ-029 Latency from the accepting edge to oDone SHALL be 1+2(S+P+H)+G cycles in nibble mode.
REQ-030 A single CNT_W-bit timer SHALL clear on every state entry and count up; the exit condition SHALL be count == N-1.
REQ-031 In IDLE, oLCD_Data and oLCD_RS SHALL keep their last driven values.

Reset
REQ-032 Reset low SHALL immediately force state IDLE, timer 0, oBusy=0, oDone=0, oLCD_Enabled=0, oLCD_RS=0, oLCD_Data=0.
REQ-033 Reset asserted mid-transfer, including during PULSE, SHALL drop oLCD_Enabled asynchronously and SHALL NOT produce oDone.
REQ-034 After Reset deasserts, the first accepted iStart SHALL behave as a fresh transfer.

Configuration
REQ-035 Macro LCD_STROBE_OVERRUN_EN defined SHALL add output oOverrun, 1 bit.
REQ-036 oOverrun SHALL be a sticky flag, set when iStart=1 while oBusy=1, and cleared only by Reset.
REQ-037 With LCD_STROBE_OVERRUN_EN undefined, port oOverrun and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults S=2, P=12, H=2, G=4; accepting edge = cycle 0)
REQ-038 8-bit write: iData=0x38, iRS=0, iNibbleMode=0 -> oLCD_Data=0x38 from cycle 1, oLCD_Enabled high cycles 3-14, oDone high at cycle 17 only.
REQ-039 Nibble write: iData=0xA5, iRS=1, iNibbleMode=1 -> oLCD_Data=0xA0 with E high cycles 3-14, then oLCD_Data=0x50 with E high cycles 23-34, oDone at cycle 37, oLCD_RS=1 throughout.
REQ-040 iStart pulsed at cycle 8 with iData=0xFF during an 8-bit transfer of 0x38 -> ignored, output stays 0x38; with LCD_STROBE_OVERRUN_EN, oOverrun=1 from cycle 9.
REQ-041 Reset pulled low at cycle 6 (in PULSE) -> oLCD_Enabled=0 and oBusy=0 without a clock edge, no oDone; a new write after release completes in 17 cycles.
REQ-042 Back-to-back writes: iStart held high continuously -> second transfer accepted in the first IDLE cycle after DONE; E pulses are separated by at least H+1+1+S cycles low.
REQ-043 Parameter corner: S=1, P=1, H=1 in 8-bit mode -> E high for exactly 1 cycle (cycle 2), oDone at cycle 4.
